// File: rtl/mac_arb_pkg.sv
// Shared types and defaults for the two-requester MAC arbiter.
package mac_arb_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int MAC_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } mac_arb_state_e;

endpackage

// File: rtl/mac_arbiter_if.sv
// Bus between two vector requesters, the arbiter and the shared Product_Sum.
interface mac_arbiter_if import mac_arb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);

  // Every valid/ready pair transfers exactly on a cycle where both are high;
  // a source holds valid and payload stable until that cycle.
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_W-1:0]     req0_ai;
  logic [DATA_W-1:0]     req0_xi;
  logic                  req0_last;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_W-1:0]     req1_ai;
  logic [DATA_W-1:0]     req1_xi;
  logic                  req1_last;

  logic [DATA_W-1:0]     mac_ai;
  logic [DATA_W-1:0]     mac_xi;
  logic                  mac_last;
  logic [2*DATA_W-1:0]   mac_result;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [2*DATA_W-1:0]   rsp_result;

  modport slave (
    input  req0_valid, req0_ai, req0_xi, req0_last,
    input  req1_valid, req1_ai, req1_xi, req1_last,
    output req0_ready, req1_ready,
    output mac_ai, mac_xi, mac_last,
    input  mac_result,
    output rsp_valid, rsp_id, rsp_result,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_ai, req0_xi, req0_last,
    output req1_valid, req1_ai, req1_xi, req1_last,
    input  req0_ready, req1_ready,
    input  mac_ai, mac_xi, mac_last,
    output mac_result,
    input  rsp_valid, rsp_id, rsp_result,
    output rsp_ready
  );

endinterface

// File: rtl/mac_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last granted index.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last_q ? 2'b01 : 2'b10;
  end

  always_comb begin
    last_d = last_q;
    if (advance && grant != 2'b00) last_d = grant[1];
  end

  // Reset to "req1 was last" so a tie after reset goes to req0.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mac_arbiter.sv
// Grants the shared Product_Sum to one requester per vector, streams its
// operand pairs, waits out the MAC latency and returns the sum.
module mac_arbiter import mac_arb_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mac_arbiter_if.slave   bus,
  output mac_arb_state_e dbg_state
);

  localparam int CNT_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

  mac_arb_state_e      state_q, state_d;
  logic                gnt_q, gnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mac_ai_q, mac_ai_d, mac_xi_q, mac_xi_d;
  logic                mac_last_q, mac_last_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [2*DATA_W-1:0] rsp_result_q, rsp_result_d;

  logic [1:0]          grant;
  logic                sel_valid, sel_last, accept, drain_done, rsp_fire, in_stream;
  logic [DATA_W-1:0]   sel_ai, sel_xi;

  rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .advance (state_q == IDLE),
    .grant   (grant)
  );

  assign sel_valid  = gnt_q ? bus.req1_valid : bus.req0_valid;
  assign sel_last   = gnt_q ? bus.req1_last  : bus.req0_last;
  assign sel_ai     = gnt_q ? bus.req1_ai    : bus.req0_ai;
  assign sel_xi     = gnt_q ? bus.req1_xi    : bus.req0_xi;
  assign in_stream  = (state_q == STREAM);
  assign accept     = in_stream && sel_valid;
  assign drain_done = (state_q == DRAIN) && (cnt_q == CNT_W'(MAC_LAT));
  assign rsp_fire   = rsp_valid_q && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      cnt_q        <= '0;
      mac_ai_q     <= '0;
      mac_xi_q     <= '0;
      mac_last_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      mac_ai_q     <= mac_ai_d;
      mac_xi_q     <= mac_xi_d;
      mac_last_q   <= mac_last_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant != 2'b00)      state_d = STREAM;
      STREAM:  if (accept && sel_last)  state_d = DRAIN;
      DRAIN:   if (drain_done)          state_d = RESP;
      RESP:    if (rsp_fire)            state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Non-accepting cycles feed zeros so the running sum in Product_Sum holds.
  always_comb begin
    gnt_d        = gnt_q;
    if (state_q == IDLE && grant != 2'b00) gnt_d = grant[1];
    mac_ai_d     = accept ? sel_ai : '0;
    mac_xi_d     = accept ? sel_xi : '0;
    mac_last_d   = accept && sel_last;
    cnt_d        = '0;
    if (state_q == DRAIN && !drain_done) cnt_d = cnt_q + CNT_W'(1);
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    if (drain_done) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt_q;
      rsp_result_d = bus.mac_result;
    end
    if (rsp_fire) rsp_valid_d = 1'b0;
  end

  assign bus.req0_ready = in_stream && !gnt_q;
  assign bus.req1_ready = in_stream &&  gnt_q;
  assign bus.mac_ai     = mac_ai_q;
  assign bus.mac_xi     = mac_xi_q;
  assign bus.mac_last   = mac_last_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter with behavioural Product_Sum models (MAC_LAT 1 and 3).
module tb_mac_arbiter;
  import mac_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mac_arbiter_if #(.DATA_W(8)) if1 ();
  mac_arbiter_if #(.DATA_W(8)) if2 ();
  mac_arb_state_e st1, st2;

  mac_arbiter #(.DATA_W(8), .MAC_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave), .dbg_state(st1));
  mac_arbiter #(.DATA_W(8), .MAC_LAT(3)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave), .dbg_state(st2));

  // clock
  always #5 clk = ~clk;

  // Product_Sum models: running accumulator, sum of the vector appears MAC_LAT cycles after mac_last
  logic [15:0] acc1, res1, prod1;
  logic [15:0] acc2, s0, s1, s2, prod2;
  assign prod1 = 16'(if1.mac_ai) * 16'(if1.mac_xi);
  assign prod2 = 16'(if2.mac_ai) * 16'(if2.mac_xi);
  assign if1.mac_result = res1;
  assign if2.mac_result = s2;

  always @(posedge clk) begin
    if (reset) begin
      acc1 <= '0; res1 <= '0;
      acc2 <= '0; s0 <= '0; s1 <= '0; s2 <= '0;
    end else begin
      acc1 <= if1.mac_last ? 16'd0 : acc1 + prod1;
      res1 <= acc1 + prod1;
      acc2 <= if2.mac_last ? 16'd0 : acc2 + prod2;
      s0   <= acc2 + prod2;
      s1   <= s0;
      s2   <= s1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one pair on requester id of dut1 and check it reaches the MAC port
  task automatic send(input int id, input logic [7:0] a, input logic [7:0] x, input logic last);
    int n = 0;
    if (id == 0) begin
      if1.req0_valid = 1'b1; if1.req0_ai = a; if1.req0_xi = x; if1.req0_last = last;
    end else begin
      if1.req1_valid = 1'b1; if1.req1_ai = a; if1.req1_xi = x; if1.req1_last = last;
    end
    while (!(id == 0 ? if1.req0_ready : if1.req1_ready) && n < 20) begin
      tick();
      n++;
    end
    check("ready_seen", 32'(n < 20), 1);
    check("other_ready", id == 0 ? if1.req1_ready : if1.req0_ready, 0);
    tick();
    check("mac_ai", if1.mac_ai, a);
    check("mac_xi", if1.mac_xi, x);
    check("mac_last", if1.mac_last, last);
    if (id == 0) if1.req0_valid = 1'b0;
    else         if1.req1_valid = 1'b0;
  endtask

  // called in the mac_last cycle: expects the response MAC_LAT+1 cycles later
  task automatic wait_rsp(input logic id, input logic [15:0] res, input int hold);
    int n = 0;
    while (!if1.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check("rsp_latency", n, 2);
    check("rsp_id", if1.rsp_id, id);
    check("rsp_result", if1.rsp_result, res);
    repeat (hold) begin
      tick();
      check("hold_valid", if1.rsp_valid, 1);
      check("hold_id", if1.rsp_id, id);
      check("hold_result", if1.rsp_result, res);
      check("hold_ready", {if1.req1_ready, if1.req0_ready}, 0);
      check("hold_state", st1, RESP);
    end
    if1.rsp_ready = 1'b1;
    tick();
    if1.rsp_ready = 1'b0;
    check("post_rsp_valid", if1.rsp_valid, 0);
    check("post_rsp_ready", {if1.req1_ready, if1.req0_ready}, 0);
    check("post_rsp_state", st1, IDLE);
  endtask

  initial begin
    int n;
    {if1.req0_valid, if1.req0_ai, if1.req0_xi, if1.req0_last} = '0;
    {if1.req1_valid, if1.req1_ai, if1.req1_xi, if1.req1_last} = '0;
    {if2.req0_valid, if2.req0_ai, if2.req0_xi, if2.req0_last} = '0;
    {if2.req1_valid, if2.req1_ai, if2.req1_xi, if2.req1_last} = '0;
    if1.rsp_ready = 1'b0;
    if2.rsp_ready = 1'b0;

    // reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_state", st1, IDLE);
    check("rst_ready", {if1.req1_ready, if1.req0_ready}, 0);
    check("rst_mac", {if1.mac_ai, if1.mac_xi, 7'd0, if1.mac_last}, 0);
    check("rst_rsp", {if1.rsp_valid, if1.rsp_id}, 0);
    check("rst_result", if1.rsp_result, 0);
    reset = 1'b0;

    // single requester, four pairs: 2+12+30+56
    send(0, 8'd1, 8'd2, 1'b0);
    send(0, 8'd3, 8'd4, 1'b0);
    send(0, 8'd5, 8'd6, 1'b0);
    send(0, 8'd7, 8'd8, 1'b1);
    check("drain_state", st1, DRAIN);
    wait_rsp(1'b0, 16'd100, 0);

    // both valid from reset: req0 wins, then req1, then req0 again
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if1.req1_valid = 1'b1; if1.req1_ai = 8'd3; if1.req1_xi = 8'd4; if1.req1_last = 1'b1;
    send(0, 8'd1, 8'd2, 1'b1);
    wait_rsp(1'b0, 16'd2, 0);
    send(1, 8'd3, 8'd4, 1'b1);
    wait_rsp(1'b1, 16'd12, 0);
    if1.req1_valid = 1'b1; if1.req1_ai = 8'd3; if1.req1_xi = 8'd4; if1.req1_last = 1'b1;
    send(0, 8'd1, 8'd2, 1'b1);
    wait_rsp(1'b0, 16'd2, 0);
    send(1, 8'd3, 8'd4, 1'b1);
    wait_rsp(1'b1, 16'd12, 0);

    // bubbles on req1 while req0 knocks: grant must hold, MAC sees zeros
    send(1, 8'd9, 8'd10, 1'b0);
    if1.req0_valid = 1'b1; if1.req0_ai = 8'd50; if1.req0_xi = 8'd50; if1.req0_last = 1'b1;
    repeat (3) begin
      tick();
      check("gap_mac", {if1.mac_ai, if1.mac_xi}, 0);
      check("gap_ready", {if1.req1_ready, if1.req0_ready}, 2'b10);
    end
    if1.req0_valid = 1'b0;
    send(1, 8'd11, 8'd12, 1'b1);
    wait_rsp(1'b1, 16'd222, 0);

    // response backpressure for 5 cycles with req1 pending
    send(0, 8'd5, 8'd5, 1'b1);
    if1.req1_valid = 1'b1; if1.req1_ai = 8'd1; if1.req1_xi = 8'd1; if1.req1_last = 1'b1;
    wait_rsp(1'b0, 16'd25, 5);
    if1.req1_valid = 1'b0;

    // reset in the middle of a vector
    send(0, 8'd1, 8'd1, 1'b0);
    send(0, 8'd2, 8'd2, 1'b0);
    if1.req0_valid = 1'b1; if1.req0_ai = 8'd3; if1.req0_xi = 8'd3; if1.req0_last = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_mac", {if1.mac_ai, if1.mac_xi, 7'd0, if1.mac_last}, 0);
    check("mid_rst_ready", {if1.req1_ready, if1.req0_ready}, 0);
    check("mid_rst_rsp", {if1.rsp_valid, if1.rsp_id}, 0);
    check("mid_rst_state", st1, IDLE);
    reset = 1'b0;
    if1.req0_valid = 1'b0;
    repeat (4) tick();
    check("no_rsp_after_rst", if1.rsp_valid, 0);
    send(0, 8'd4, 8'd5, 1'b0);
    send(0, 8'd6, 8'd7, 1'b1);
    wait_rsp(1'b0, 16'd62, 0);

    // MAC_LAT=3 instance: 6+20
    if2.req0_valid = 1'b1; if2.req0_ai = 8'd2; if2.req0_xi = 8'd3; if2.req0_last = 1'b0;
    n = 0;
    while (!if2.req0_ready && n < 20) begin tick(); n++; end
    check("l3_ready", 32'(n < 20), 1);
    tick();
    check("l3_mac_ai", if2.mac_ai, 8'd2);
    if2.req0_ai = 8'd4; if2.req0_xi = 8'd5; if2.req0_last = 1'b1;
    tick();
    if2.req0_valid = 1'b0;
    check("l3_mac_last", {if2.mac_last, if2.mac_xi}, {1'b1, 8'd5});
    n = 0;
    while (!if2.rsp_valid && n < 50) begin tick(); n++; end
    check("l3_latency", n, 4);
    check("l3_result", if2.rsp_result, 16'd26);
    check("l3_id", if2.rsp_id, 0);
    if2.rsp_ready = 1'b1;
    tick();
    if2.rsp_ready = 1'b0;
    check("l3_done", {if2.rsp_valid, 6'd0, st2}, {1'b0, 6'd0, IDLE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameter MAC_LAT, default 1: cycles from the mac_last cycle to the cycle in which mac_result holds the final sum.
REQ-002 Parameter DATA_W, default 8: operand width; result width is 2*DATA_W.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0_valid, req1_valid  in  1  requester n presents an operand pair.
REQ-006 req0_ai, req1_ai, req0_xi, req1_xi  in  DATA_W  coefficient and variable operands.
REQ-007 req0_last, req1_last  in  1  marks the final pair of a vector.
REQ-008 req0_ready, req1_ready  out  1  pair accepted when valid and ready are both high.
REQ-009 mac_ai, mac_xi  out  DATA_W  registered operands to the shared Product_Sum.
REQ-010 mac_last  out  1  registered last_input to Product_Sum.
REQ-011 mac_result  in  2*DATA_W  Product_Sum result.
REQ-012 rsp_valid  out  1 / rsp_id  out  1 / rsp_result  out  2*DATA_W  response to the owning requester.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.

Function
REQ-014 The FSM SHALL have the states IDLE, STREAM, DRAIN and RESP.
REQ-015 In IDLE with any reqN_valid high, the block SHALL grant one requester for a whole vector and move to STREAM on the next cycle.
REQ-016 Arbitration SHALL be round-robin: when both requesters are valid, the grant goes to the requester not granted last; otherwise it goes to the only valid requester.
REQ-017 Grant decisions SHALL be made only in IDLE; the grant SHALL NOT change before the vector's last pair is accepted.
REQ-018 In STREAM, only the granted requester's ready SHALL be high; the other requester's ready SHALL be 0.
REQ-019 An accepted pair SHALL appear on mac_ai/mac_xi one cycle after acceptance.
REQ-020 In any cycle with no accepted pair (bubble, IDLE, DRAIN, RESP), mac_ai and mac_xi SHALL be 0, so the accumulated sum is unchanged.
REQ-021 mac_last SHALL be a one-cycle pulse, aligned with the operands of the accepted last pair.
REQ-022 Acceptance of a last pair SHALL move the FSM STREAM->DRAIN and drop ready in the next cycle.
REQ-023 A single-pair vector (last on the first beat) SHALL be supported.
REQ-024 In DRAIN, a counter SHALL count MAC_LAT cycles from the mac_last cycle; mac_result SHALL be captured into rsp_result exactly MAC_LAT cycles after the mac_last cycle, and the FSM SHALL move to RESP.
REQ-025 In RESP, rsp_valid SHALL be high and rsp_id SHALL equal the granted index.
REQ-026 rsp_valid, rsp_id and rsp_result SHALL be held stable until rsp_ready is high.
REQ-027 On the rsp_valid and rsp_ready handshake, the FSM SHALL return to IDLE; a new grant MAY be issued in the cycle after the handshake, never in the same cycle.
REQ-028 The result SHALL be passed through unmodified; 2*DATA_W wrap-around is owned by Product_Sum.
REQ-029 Minimum per-vector overhead: 1 grant cycle + MAC_LAT cycles + 1 response cycle.

Reset
REQ-030 While reset is high at a clock edge: FSM->IDLE; all ready, mac_ai, mac_xi, mac_last, rsp_valid, rsp_id and rsp_result->0; round-robin pointer favours req0; drain counter->0.
REQ-031 Reset asserted mid-vector or mid-response SHALL abandon that vector without emitting a response.
REQ-032 Product_Sum SHALL share the same reset.

Structure
REQ-033 Package mac_arb_pkg SHALL hold the FSM state enum, the DATA_W default, and the MAC_LAT default.
REQ-034 The 2-way round-robin grant logic SHALL be the sub-module rr_arb2 (inputs req[1:0], advance; output grant[1:0], one-hot or zero).

Verification
REQ-035 Single requester, MAC_LAT=1: req0 sends (1,2),(3,4),(5,6),(7,8 last) -> rsp_valid with rsp_id=0 and rsp_result=100.
REQ-036 Both requesters valid from reset: req0 sends (1,2 last) and req1 sends (3,4 last) -> responses in order id0=2, then id1=12; a second pair of requests gives id0 first again.
REQ-037 Bubbles: req1 sends (9,10), then valid low for 3 cycles, then (11,12 last) -> mac_ai/mac_xi are 0 during the gap and rsp_result=222.
REQ-038 Backpressure: rsp_ready held low for 5 cycles -> rsp_* stable for all 5 cycles, no new grant, req ready=0.
REQ-039 Reset asserted during STREAM after 2 pairs -> the next cycle shows all outputs 0, no response, and a fresh vector afterwards gives the correct sum.
REQ-040 MAC_LAT=3 with a behavioural MAC model -> result captured exactly 3 cycles after mac_last.
